ram_bridge: RTL and testbench

Bus responder on the machine's RAM port: accepts 32-bit CPU accesses (`RAM_CEn`/`RAM_WEn`/`RAM_BEn`, answered with `RAM_READYn`) and splits each into up to two 16-bit request/acknowledge transactions on an external halfword memory. It sits between the machine top's RAM port and the SDRAM/BRAM halfword controller. It is the target end of the CPU-initiated RAM cycle.

---
 rtl/ram_bridge.sv | 188 ++++++++++++++++++
 tb/tb_ram_bridge.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ram_bridge.sv
// ram_bridge: splits 32-bit CPU RAM accesses into up to two 16-bit req/ack halfword
// transactions. Define RAM_BRIDGE_WDT_EN to enable the ack watchdog driving ERR.
module ram_bridge (
  input  logic        CLK,
  input  logic        RES,
  input  logic        CE,
  input  logic [20:0] A,
  input  logic [31:0] DI,
  output logic [31:0] DO,
  input  logic        CEn,
  input  logic        WEn,
  input  logic [3:0]  BEn,
  output logic        READYn,
  output logic        ERR,
  output logic [19:0] MEM_A,
  output logic [15:0] MEM_DO,
  input  logic [15:0] MEM_DI,
  output logic        MEM_WE,
  output logic [1:0]  MEM_BE,
  output logic        MEM_REQ,
  input  logic        MEM_ACK
);
  // state | meaning
  // IDLE  | waiting for CEn=0; latches the access
  // LO    | low halfword request outstanding
  // GAP   | one cycle with MEM_REQ low between the halves
  // HI    | high halfword request outstanding
  // DONE  | READYn low for one cycle
  typedef enum logic [2:0] {IDLE, LO, GAP, HI, DONE} state_t;
  state_t state, nxt;

  logic [18:0] a_q;
  logic [31:0] di_q;
  logic [3:0]  ben_q;
  logic        wen_q;
  logic        abort_q;

  logic [31:0] do_d;
  logic [19:0] mem_a_d;
  logic [15:0] mem_do_d;
  logic [1:0]  mem_be_d;
  logic        we_d, req_d, readyn_d, abort_d;

  logic        start, ack, aborting, timeout;
  logic [18:0] cur_a;
  logic [31:0] cur_di;
  logic [3:0]  cur_ben;
  logic        unused_ok;

  assign unused_ok = ^A[1:0];
  assign start     = (state == IDLE) && !CEn;
  // an ack only counts against a live request
  assign ack       = MEM_ACK && MEM_REQ;
  assign aborting  = abort_q || CEn;
  assign cur_a     = (state == IDLE) ? A[20:2] : a_q;
  assign cur_di    = (state == IDLE) ? DI : di_q;
  assign cur_ben   = (state == IDLE) ? BEn : ben_q;

`ifdef RAM_BRIDGE_WDT_EN
  logic [7:0] wdt_q;
  logic       err_q;

  assign timeout = MEM_REQ && !MEM_ACK && (wdt_q == 8'd0);
  assign ERR     = err_q;

  // down-counter reloaded on each new request; zero on the 255th cycle without ack
  always_ff @(posedge CLK or posedge RES) begin
    if (RES) begin
      wdt_q <= 8'd254;
      err_q <= 1'b0;
    end else if (CE) begin
      if (req_d && !MEM_REQ)
        wdt_q <= 8'd254;
      else if (MEM_REQ && wdt_q != 8'd0)
        wdt_q <= wdt_q - 8'd1;
      if (timeout)
        err_q <= 1'b1;
    end
  end
`else
  assign timeout = 1'b0;
  assign ERR     = 1'b0;
`endif

  always_ff @(posedge CLK or posedge RES) begin
    if (RES) begin
      state   <= IDLE;
      a_q     <= '0;
      di_q    <= '0;
      ben_q   <= 4'hF;
      wen_q   <= 1'b1;
      abort_q <= 1'b0;
      DO      <= '0;
      READYn  <= 1'b1;
      MEM_REQ <= 1'b0;
      MEM_WE  <= 1'b0;
      MEM_BE  <= '0;
      MEM_A   <= '0;
      MEM_DO  <= '0;
    end else if (CE) begin
      state <= nxt;
      if (start) begin
        a_q   <= A[20:2];
        di_q  <= DI;
        ben_q <= BEn;
        wen_q <= WEn;
      end
      abort_q <= abort_d;
      DO      <= do_d;
      READYn  <= readyn_d;
      MEM_REQ <= req_d;
      MEM_WE  <= we_d;
      MEM_BE  <= mem_be_d;
      MEM_A   <= mem_a_d;
      MEM_DO  <= mem_do_d;
    end
  end

  always_comb begin
    nxt = state;
    case (state)
      IDLE: begin
        if (!CEn) begin
          if (BEn[1:0] != 2'b11)      nxt = LO;
          else if (BEn[3:2] != 2'b11) nxt = HI;
          else                        nxt = DONE;
        end
      end
      LO: begin
        if (ack) begin
          if (aborting)                  nxt = IDLE;
          else if (ben_q[3:2] != 2'b11)  nxt = GAP;
          else                           nxt = DONE;
        end else if (timeout) begin
          nxt = aborting ? IDLE : DONE;
        end
      end
      GAP:  nxt = aborting ? IDLE : HI;
      HI: begin
        if (ack || timeout) nxt = aborting ? IDLE : DONE;
      end
      DONE: nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  always_comb begin
    do_d     = DO;
    mem_a_d  = MEM_A;
    mem_do_d = MEM_DO;
    mem_be_d = MEM_BE;
    we_d     = MEM_WE;
    abort_d  = 1'b0;
    req_d    = (nxt == LO) || (nxt == HI);
    readyn_d = (nxt != DONE);

    if (start) begin
      do_d = '0;
      we_d = ~WEn;
    end else if (state == LO || state == GAP || state == HI) begin
      abort_d = abort_q || CEn;
    end

    if (nxt == LO) begin
      mem_a_d  = {cur_a, 1'b0};
      mem_be_d = ~cur_ben[1:0];
      mem_do_d = cur_di[15:0];
    end else if (nxt == HI) begin
      mem_a_d  = {cur_a, 1'b1};
      mem_be_d = ~cur_ben[3:2];
      mem_do_d = cur_di[31:16];
    end

    if (wen_q) begin
      if (state == LO && ack) do_d[15:0]  = MEM_DI;
      if (state == HI && ack) do_d[31:16] = MEM_DI;
      // timed-out reads report all-ones for every enabled half not yet fetched
      if (timeout) begin
        if (state == LO) begin
          do_d[15:0] = 16'hFFFF;
          if (ben_q[3:2] != 2'b11) do_d[31:16] = 16'hFFFF;
        end
        if (state == HI) do_d[31:16] = 16'hFFFF;
      end
    end
  end

endmodule

// File: tb/tb_ram_bridge.sv
// tb_ram_bridge: table-driven checks of ram_bridge against a small req/ack
// halfword memory model, plus hand sequences for abort, reset, CE freeze and timeout.
module tb_ram_bridge;
  localparam int NEVER = 1000000;

  logic        CLK, RES, CE, CEn, WEn;
  logic [20:0] A;
  logic [31:0] DI, DO;
  logic [3:0]  BEn;
  logic        READYn, ERR;
  logic [19:0] MEM_A;
  logic [15:0] MEM_DO, MEM_DI;
  logic        MEM_WE, MEM_REQ, MEM_ACK;
  logic [1:0]  MEM_BE;

  ram_bridge dut (
    .CLK(CLK), .RES(RES), .CE(CE), .A(A), .DI(DI), .DO(DO),
    .CEn(CEn), .WEn(WEn), .BEn(BEn), .READYn(READYn), .ERR(ERR),
    .MEM_A(MEM_A), .MEM_DO(MEM_DO), .MEM_DI(MEM_DI), .MEM_WE(MEM_WE),
    .MEM_BE(MEM_BE), .MEM_REQ(MEM_REQ), .MEM_ACK(MEM_ACK)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  int tests = 0;
  int fails = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // halfword memory model: acks each request ack_delay samples after it rises
  int          ack_delay = 0;
  int          age = 0, nreq = 0, min_gap = 999, gap_cnt = 0, unstable = 0;
  logic        prev_req = 1'b0, acked = 1'b0, ce_s;
  logic [15:0] rd_lo = '0, rd_hi = '0;
  logic [19:0] first_a, last_a;
  logic [1:0]  last_be;
  logic [15:0] last_do;
  logic        last_we;
  logic [38:0] held;

  initial begin
    MEM_ACK = 1'b0;
    MEM_DI  = '0;
    forever begin
      @(posedge CLK);
      ce_s = CE;
      #1;
      if (ce_s) begin
        MEM_ACK = 1'b0;
        if (MEM_REQ) begin
          if (!prev_req) begin
            nreq++;
            if (nreq == 1) first_a = MEM_A;
            else if (gap_cnt < min_gap) min_gap = gap_cnt;
            last_a  = MEM_A;
            last_be = MEM_BE;
            last_do = MEM_DO;
            last_we = MEM_WE;
            held    = {MEM_A, MEM_BE, MEM_DO, MEM_WE};
            age     = 0;
            acked   = 1'b0;
          end else if ({MEM_A, MEM_BE, MEM_DO, MEM_WE} !== held) begin
            unstable++;
          end
          if (!acked && age == ack_delay) begin
            MEM_ACK = 1'b1;
            acked   = 1'b1;
            MEM_DI  = MEM_A[0] ? rd_hi : rd_lo;
          end
          age++;
          gap_cnt = 0;
        end else begin
          gap_cnt++;
        end
        prev_req = MEM_REQ;
      end
    end
  end

  typedef struct {
    logic [20:0] a;
    logic [31:0] di;
    logic [3:0]  ben;
    logic        wen;
    int          ack_delay;
    logic [15:0] rd_lo;
    logic [15:0] rd_hi;
    logic [31:0] exp_do;
    int          exp_lat;
    int          exp_nreq;
    logic [19:0] exp_first_a;
    logic [19:0] exp_last_a;
    logic [1:0]  exp_last_be;
    logic [15:0] exp_last_do;
    logic        exp_we;
  } vec_t;

  task automatic check_reset(input string p);
    chk({p, "_readyn"}, READYn, 1);
    chk({p, "_do"}, DO, 0);
    chk({p, "_req"}, MEM_REQ, 0);
    chk({p, "_we"}, MEM_WE, 0);
    chk({p, "_be"}, MEM_BE, 0);
    chk({p, "_mem_a"}, MEM_A, 0);
    chk({p, "_mem_do"}, MEM_DO, 0);
    chk({p, "_err"}, ERR, 0);
  endtask

  // called #1 after a clock edge; returns #1 after the edge following the READYn pulse
  task automatic do_access(input int id, input vec_t v);
    int lat;
    bit got;
    ack_delay = v.ack_delay;
    rd_lo = v.rd_lo;
    rd_hi = v.rd_hi;
    nreq = 0;
    min_gap = 999;
    unstable = 0;
    A = v.a; DI = v.di; BEn = v.ben; WEn = v.wen; CEn = 1'b0;
    lat = 0;
    got = 1'b0;
    while (!got && lat < 100) begin
      @(posedge CLK); #1;
      lat++;
      if (!READYn) got = 1'b1;
    end
    CEn = 1'b1;
    chk($sformatf("v%0d_latency", id), lat, v.exp_lat);
    chk($sformatf("v%0d_do", id), DO, v.exp_do);
    @(posedge CLK); #1;
    chk($sformatf("v%0d_ready_one_cycle", id), READYn, 1);
    chk($sformatf("v%0d_do_hold", id), DO, v.exp_do);
    chk($sformatf("v%0d_nreq", id), nreq, v.exp_nreq);
    if (v.exp_nreq > 0) begin
      chk($sformatf("v%0d_first_a", id), first_a, v.exp_first_a);
      chk($sformatf("v%0d_last_a", id), last_a, v.exp_last_a);
      chk($sformatf("v%0d_last_be", id), last_be, v.exp_last_be);
      chk($sformatf("v%0d_last_do", id), last_do, v.exp_last_do);
      chk($sformatf("v%0d_we", id), last_we, v.exp_we);
      chk($sformatf("v%0d_stable", id), unstable, 0);
    end
    if (v.exp_nreq == 2) chk($sformatf("v%0d_gap", id), (min_gap >= 1), 1);
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1);
  end

  vec_t vecs[7];
  int lat, n, req_hi, diffs;
  bit got, rdy_low;
  logic [72:0] snap;

  initial begin
    // halfword address = byte address / 2
    vecs[0] = '{21'h000104, 32'h0, 4'b0000, 1'b1, 0, 16'h5678, 16'h1234, 32'h12345678, 4, 2,
                20'h00082, 20'h00083, 2'b11, 16'h0000, 1'b0};
    vecs[1] = '{21'h000010, 32'hAABBCCDD, 4'b1100, 1'b0, 0, 16'h0, 16'h0, 32'h0, 2, 1,
                20'h00008, 20'h00008, 2'b11, 16'hCCDD, 1'b1};
    vecs[2] = '{21'h1FFFFC, 32'h0, 4'b0011, 1'b1, 0, 16'hDEAD, 16'hBEEF, 32'hBEEF0000, 2, 1,
                20'hFFFFF, 20'hFFFFF, 2'b11, 16'h0000, 1'b0};
    vecs[3] = '{21'h000008, 32'h0, 4'b1111, 1'b1, 0, 16'h0, 16'h0, 32'h0, 1, 0,
                20'h0, 20'h0, 2'b00, 16'h0, 1'b0};
    vecs[4] = '{21'h000020, 32'h11223344, 4'b0110, 1'b0, 2, 16'h0, 16'h0, 32'h0, 8, 2,
                20'h00010, 20'h00011, 2'b10, 16'h1122, 1'b1};
    vecs[5] = '{21'h000040, 32'h0, 4'b1101, 1'b1, 3, 16'hA5A5, 16'h0, 32'h0000A5A5, 5, 1,
                20'h00020, 20'h00020, 2'b10, 16'h0000, 1'b0};
    vecs[6] = '{21'h0ABCD8, 32'h0, 4'b0111, 1'b1, 1, 16'h0, 16'h00C3, 32'h00C30000, 3, 1,
                20'h55E6D, 20'h55E6D, 2'b10, 16'h0000, 1'b0};

    RES = 1'b1; CE = 1'b1; CEn = 1'b1; WEn = 1'b1; BEn = 4'hF; A = '0; DI = '0;
    repeat (2) @(posedge CLK);
    #1;
    check_reset("reset");
    RES = 1'b0;
    @(posedge CLK); #1;

    for (int i = 0; i < 7; i++) do_access(i, vecs[i]);

    // CPU abort during LO with a slow ack: request held, no HI, no READYn
    ack_delay = 5; nreq = 0;
    A = 21'h000200; DI = '0; BEn = 4'b0000; WEn = 1'b1; CEn = 1'b0;
    @(posedge CLK); #1;
    CEn = 1'b1;
    req_hi = 0; rdy_low = 1'b0; n = 0;
    while (MEM_REQ && n < 40) begin
      req_hi++;
      if (!READYn) rdy_low = 1'b1;
      @(posedge CLK); #1;
      n++;
    end
    chk("abort_req_held", req_hi, 6);
    repeat (4) begin
      if (!READYn) rdy_low = 1'b1;
      @(posedge CLK); #1;
    end
    chk("abort_no_ready", rdy_low, 0);
    chk("abort_no_hi_req", nreq, 1);
    chk("abort_req_low", MEM_REQ, 0);
    do_access(10, vecs[0]);

    // reset pulse while the HI request is outstanding
    ack_delay = 3; nreq = 0;
    A = 21'h000104; BEn = 4'b0000; WEn = 1'b1; CEn = 1'b0;
    n = 0;
    do begin
      @(posedge CLK); #1;
      n++;
    end while (!(MEM_REQ && MEM_A[0]) && n < 40);
    chk("res_reached_hi", MEM_REQ && MEM_A[0], 1);
    #2;
    RES = 1'b1;
    #1;
    check_reset("res_mid");
    CEn = 1'b1;
    @(posedge CLK); #1;
    RES = 1'b0;
    @(posedge CLK); #1;
    do_access(11, vecs[1]);

    // CE held low for 10 cycles inside LO with ack already presented
    ack_delay = 1; rd_lo = 16'h1111; rd_hi = 16'h2222;
    A = 21'h000300; BEn = 4'b0000; WEn = 1'b1; CEn = 1'b0;
    repeat (2) begin
      @(posedge CLK); #1;
    end
    CE = 1'b0;
    snap = {DO, READYn, MEM_REQ, MEM_A, MEM_DO, MEM_BE, MEM_WE};
    diffs = 0;
    repeat (10) begin
      @(posedge CLK); #1;
      if ({DO, READYn, MEM_REQ, MEM_A, MEM_DO, MEM_BE, MEM_WE} !== snap) diffs++;
    end
    chk("freeze_outputs", diffs, 0);
    chk("freeze_req_high", MEM_REQ, 1);
    CE = 1'b1;
    lat = 0; got = 1'b0;
    while (!got && lat < 40) begin
      @(posedge CLK); #1;
      lat++;
      if (!READYn) got = 1'b1;
    end
    CEn = 1'b1;
    chk("freeze_resume_latency", lat, 4);
    chk("freeze_do", DO, 32'h22221111);
    @(posedge CLK); #1;

`ifdef RAM_BRIDGE_WDT_EN
    ack_delay = NEVER;
    A = 21'h000400; BEn = 4'b0000; WEn = 1'b1; CEn = 1'b0;
    lat = 0; got = 1'b0;
    while (!got && lat < 400) begin
      @(posedge CLK); #1;
      lat++;
      if (!READYn) got = 1'b1;
    end
    CEn = 1'b1;
    chk("wdt_latency", lat, 256);
    chk("wdt_do", DO, 32'hFFFFFFFF);
    chk("wdt_err", ERR, 1);
    repeat (5) begin
      @(posedge CLK); #1;
    end
    chk("wdt_err_sticky", ERR, 1);
    chk("wdt_req_dropped", MEM_REQ, 0);
`else
    ack_delay = NEVER;
    A = 21'h000400; BEn = 4'b0000; WEn = 1'b1; CEn = 1'b0;
    rdy_low = 1'b0;
    repeat (1000) begin
      @(posedge CLK); #1;
      if (!READYn) rdy_low = 1'b1;
    end
    chk("nowdt_still_waiting", MEM_REQ, 1);
    chk("nowdt_no_ready", rdy_low, 0);
    chk("nowdt_err", ERR, 0);
`endif
    CEn = 1'b1;
    RES = 1'b1;
    @(posedge CLK); #1;
    RES = 1'b0;
    check_reset("final_reset");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
